// File: rtl/mic1_pkg.sv
// Shared types and constants for the MIC-1 memory controller.
package mic1_pkg;

  // Per-port request/ack FSM state.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } port_state_e;

  // Bit positions of the memory strobes within the MIR strobe field.
  localparam int unsigned MIR_WR_BIT    = 0;
  localparam int unsigned MIR_RD_BIT    = 1;
  localparam int unsigned MIR_FETCH_BIT = 2;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/mic1_mem_port.sv
// Generic request/ack port: captures address, write enable and write data on start,
// holds the request until ack. A start coincident with the ack chains straight into a
// new transaction without an idle cycle.
module mic1_mem_port
  import mic1_pkg::*;
#(
  parameter int unsigned AW = ADDR_W_DEF,
  parameter int unsigned DW = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          start_we,
  input  logic [AW-1:0] start_addr,
  input  logic [DW-1:0] start_wdata,
  output logic          req,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic          ack,
  output logic          busy,
  output logic          done
);

  port_state_e   state_q, state_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          accept;

  // Next state: IDLE -> BUSY on start, BUSY -> IDLE on ack unless chained.
  always_comb begin
    done    = (state_q == BUSY) && ack;
    accept  = start && ((state_q == IDLE) || done);
    state_d = state_q;
    if (accept) begin
      state_d = BUSY;
    end else if (done) begin
      state_d = IDLE;
    end
  end

  // State and request-field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= start_we;
        addr_q  <= start_addr;
        wdata_q <= start_wdata;
      end
    end
  end

  assign req   = (state_q == BUSY);
  assign busy  = req;
  assign we    = req && we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

// File: rtl/mic1_memctl.sv
// MIC-1 memory controller: word data port (MAR/MDR) and byte instruction port (PC/MBR).
// Optional one-byte instruction prefetch buffer: define MIC1_MEMCTL_PREFETCH_EN.
module mic1_memctl
  import mic1_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [DATA_W-1:0] MDR_in,
  input  logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] MDR_out,
  output logic              mdr_load,
  output logic [7:0]        MBR,
  output logic              mbr_load,
  output logic              stall,
  output logic              proto_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata
);

  logic [2:0]        strb;
  logic              data_start, data_busy, data_done;
  logic              byte_start, byte_busy, byte_done, byte_stall;
  logic [ADDR_W-1:0] byte_start_addr;
  logic              unused_byte_we;
  logic [7:0]        unused_byte_wdata;
  logic              unused_byte;

  assign strb[MIR_WR_BIT]    = wr;
  assign strb[MIR_RD_BIT]    = rd;
  assign strb[MIR_FETCH_BIT] = fetch;

  // rd together with wr issues the write; the read is dropped.
  assign data_start = !stall && (strb[MIR_RD_BIT] || strb[MIR_WR_BIT]);
  assign stall      = data_busy || byte_stall;
  assign mdr_load   = data_done && !mem_we;

  mic1_mem_port #(.AW(ADDR_W), .DW(DATA_W)) u_data_port (
    .clk         (clk),
    .rst         (rst),
    .start       (data_start),
    .start_we    (strb[MIR_WR_BIT]),
    .start_addr  (MAR),
    .start_wdata (MDR_in),
    .req         (mem_req),
    .we          (mem_we),
    .addr        (mem_addr),
    .wdata       (mem_wdata),
    .ack         (mem_ack),
    .busy        (data_busy),
    .done        (data_done)
  );

  mic1_mem_port #(.AW(ADDR_W), .DW(8)) u_byte_port (
    .clk         (clk),
    .rst         (rst),
    .start       (byte_start),
    .start_we    (1'b0),
    .start_addr  (byte_start_addr),
    .start_wdata (8'h00),
    .req         (imem_req),
    .we          (unused_byte_we),
    .addr        (imem_addr),
    .wdata       (unused_byte_wdata),
    .ack         (imem_ack),
    .busy        (byte_busy),
    .done        (byte_done)
  );

  assign unused_byte = ^{unused_byte_we, unused_byte_wdata};

  // MDR capture and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      MDR_out   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (mdr_load) MDR_out <= mem_rdata;
      if (!stall && strb[MIR_RD_BIT] && strb[MIR_WR_BIT]) proto_err <= 1'b1;
    end
  end

`ifdef MIC1_MEMCTL_PREFETCH_EN
  logic              buf_valid_q, pf_q, pf_live_q, pend_q, hit_q;
  logic [ADDR_W-1:0] buf_addr_q, pend_addr_q;
  logic [7:0]        buf_data_q;
  logic              fetch_acc, wr_acc, start_pf, hit_take, join_same, join_diff;
  logic              mbr_from_port;

  assign fetch_acc = !stall && strb[MIR_FETCH_BIT];
  assign wr_acc    = !stall && strb[MIR_WR_BIT];
  // A prefetch nobody is waiting for must not freeze the sequencer.
  assign byte_stall    = (byte_busy && !pf_q) || pend_q;
  assign mbr_from_port = byte_done && (!pf_q || (fetch_acc && imem_addr == PC));
  assign mbr_load      = mbr_from_port || hit_q;

  // Byte port scheduling: chain after an ack, serve a buffer hit, join or queue behind
  // an outstanding prefetch, or start a plain demand fetch.
  always_comb begin
    byte_start      = 1'b0;
    byte_start_addr = PC;
    start_pf        = 1'b0;
    hit_take        = 1'b0;
    join_same       = 1'b0;
    join_diff       = 1'b0;
    if (byte_done && pend_q) begin
      byte_start      = 1'b1;
      byte_start_addr = pend_addr_q;
    end else if (byte_done && !pf_q) begin
      byte_start      = 1'b1;
      byte_start_addr = imem_addr + ADDR_W'(1);
      start_pf        = 1'b1;
    end else if (fetch_acc) begin
      if (byte_busy && !byte_done) begin
        join_same = (imem_addr == PC);
        join_diff = (imem_addr != PC);
      end else if (mbr_from_port || (buf_valid_q && buf_addr_q == PC)) begin
        byte_start      = 1'b1;
        byte_start_addr = PC + ADDR_W'(1);
        start_pf        = 1'b1;
        hit_take        = !byte_done;
      end else begin
        byte_start = 1'b1;
      end
    end
  end

  // Prefetch buffer, MBR and bookkeeping for outstanding prefetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      MBR         <= '0;
      hit_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      pf_q        <= 1'b0;
      pf_live_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      hit_q <= hit_take;
      if (hit_take) MBR <= buf_data_q;
      else if (mbr_from_port) MBR <= imem_rdata;
      if (byte_done && pf_q && !pend_q && !mbr_from_port) begin
        buf_valid_q <= pf_live_q;
        buf_addr_q  <= imem_addr;
        buf_data_q  <= imem_rdata;
      end
      if (byte_start && start_pf) buf_valid_q <= 1'b0;
      if (wr_acc) buf_valid_q <= 1'b0;
      if (byte_start) pf_q <= start_pf;
      else if (byte_done || join_same) pf_q <= 1'b0;
      // A write after the prefetch was issued makes its byte stale.
      if (byte_start) pf_live_q <= !wr_acc;
      else if (wr_acc) pf_live_q <= 1'b0;
      if (byte_done) pend_q <= 1'b0;
      else if (join_diff) begin
        pend_q      <= 1'b1;
        pend_addr_q <= PC;
      end
    end
  end
`else
  assign byte_start      = !stall && strb[MIR_FETCH_BIT];
  assign byte_start_addr = PC;
  assign byte_stall      = byte_busy;
  assign mbr_load        = byte_done;

  // MBR capture on byte-port ack.
  always_ff @(posedge clk) begin
    if (rst) MBR <= '0;
    else if (byte_done) MBR <= imem_rdata;
  end
`endif

endmodule

// File: tb/tb_mic1_memctl.sv
// Self-checking bench for mic1_memctl with wait-state programmable memories.
module tb_mic1_memctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0, fetch = 1'b0;
  logic [31:0] MAR = '0, MDR_in = '0, PC = '0;
  logic [31:0] MDR_out;
  logic        mdr_load, mbr_load, stall, proto_err;
  logic [7:0]  MBR;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr;
  logic [7:0]  imem_rdata;

  int n_cmp = 0, n_bad = 0;
  int dwait = 0, iwait = 0, dcnt = 0, icnt = 0, wr_count = 0;
  logic force_dack = 1'b0;

  logic [31:0] init_mem [256];
  logic [31:0] dmem     [256];
  bit          dvalid   [256];
  logic [7:0]  imem_tbl [256];
  logic [31:0] ref_mem  [256];
  logic [31:0] mdr_model = '0;
  logic        proto_model = 1'b0;

  always #5 clk = ~clk;

  mic1_memctl dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .fetch(fetch),
    .MAR(MAR), .MDR_in(MDR_in), .PC(PC),
    .MDR_out(MDR_out), .mdr_load(mdr_load), .MBR(MBR), .mbr_load(mbr_load),
    .stall(stall), .proto_err(proto_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata)
  );

  // Memories: ack after the programmed number of wait cycles.
  assign mem_ack    = (mem_req && dcnt == dwait) || force_dack;
  assign mem_rdata  = dvalid[mem_addr[7:0]] ? dmem[mem_addr[7:0]] : init_mem[mem_addr[7:0]];
  assign imem_ack   = imem_req && icnt == iwait;
  assign imem_rdata = imem_tbl[imem_addr[7:0]];

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) dcnt <= 0; else dcnt <= dcnt + 1;
    if (rst || !imem_req || imem_ack) icnt <= 0; else icnt <= icnt + 1;
    if (!rst && mem_req && mem_ack && mem_we) begin
      dmem[mem_addr[7:0]]   <= mem_wdata;
      dvalid[mem_addr[7:0]] <= 1'b1;
      wr_count              <= wr_count + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0; fetch = 1'b0; force_dack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdr_model = '0;
    proto_model = 1'b0;
  endtask

  // One data transaction, issued at the current negedge; returns at the negedge where
  // stall has dropped so the next call is back-to-back.
  task automatic data_txn(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input string tag);
    int stall_cnt = 0, load_cnt = 0, load_at = 0, req_cnt = 0, we_cnt = 0, bad_fld = 0;
    int wr0;
    logic        exp_load;
    logic [31:0] exp_mdr;
    exp_load = r && !w;
    exp_mdr  = exp_load ? ref_mem[a[7:0]] : mdr_model;
    wr0 = wr_count;
    dwait = waits;
    rd = r; wr = w; MAR = a; MDR_in = d;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin rd = 1'b0; wr = 1'b0; MAR = ~a; MDR_in = ~d; end
      if (stall) stall_cnt++;
      if (mdr_load) begin load_cnt++; load_at = c; end
      if (mem_req) begin
        req_cnt++;
        if (mem_we) we_cnt++;
        if (mem_addr !== a || (w && mem_wdata !== d)) bad_fld++;
      end
      if (!stall) break;
    end
    proto_model = proto_model | (r & w);
    n_cmp++; if (stall_cnt != waits + 1) begin n_bad++;
      $display("FAIL %s stall cycles: got %0d want %0d", tag, stall_cnt, waits + 1); end
    n_cmp++; if (req_cnt != waits + 1) begin n_bad++;
      $display("FAIL %s req cycles: got %0d want %0d", tag, req_cnt, waits + 1); end
    n_cmp++; if (we_cnt != (w ? waits + 1 : 0)) begin n_bad++;
      $display("FAIL %s we cycles: got %0d want %0d", tag, we_cnt, w ? waits + 1 : 0); end
    n_cmp++; if (load_cnt != int'(exp_load)) begin n_bad++;
      $display("FAIL %s mdr_load count: got %0d want %0d", tag, load_cnt, exp_load); end
    if (exp_load) begin
      n_cmp++; if (load_at != waits + 1) begin n_bad++;
        $display("FAIL %s mdr_load cycle: got %0d want %0d", tag, load_at, waits + 1); end
    end
    n_cmp++; if (bad_fld != 0) begin n_bad++;
      $display("FAIL %s request fields unstable: got %0d bad cycles want 0", tag, bad_fld); end
    n_cmp++; if (MDR_out !== exp_mdr) begin n_bad++;
      $display("FAIL %s MDR_out: got %h want %h", tag, MDR_out, exp_mdr); end
    n_cmp++; if (wr_count - wr0 != int'(w)) begin n_bad++;
      $display("FAIL %s bus writes: got %0d want %0d", tag, wr_count - wr0, w); end
    n_cmp++; if (proto_err !== proto_model) begin n_bad++;
      $display("FAIL %s proto_err: got %b want %b", tag, proto_err, proto_model); end
    if (w) ref_mem[a[7:0]] = d;
    if (exp_load) mdr_model = exp_mdr;
  endtask

  // One demand fetch with no buffered byte available.
  task automatic fetch_txn(input logic [31:0] pc, input int waits, input string tag);
    int stall_cnt = 0, load_cnt = 0, load_at = 0, bad_fld = 0;
    iwait = waits;
    fetch = 1'b1; PC = pc;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin fetch = 1'b0; PC = ~pc; end
      if (stall) begin
        stall_cnt++;
        if (!imem_req || imem_addr !== pc) bad_fld++;
      end
      if (mbr_load) begin load_cnt++; load_at = c; end
      if (!stall) break;
    end
    n_cmp++; if (stall_cnt != waits + 1) begin n_bad++;
      $display("FAIL %s stall cycles: got %0d want %0d", tag, stall_cnt, waits + 1); end
    n_cmp++; if (load_cnt != 1 || load_at != waits + 1) begin n_bad++;
      $display("FAIL %s mbr_load: got %0d pulses at %0d want 1 at %0d",
               tag, load_cnt, load_at, waits + 1); end
    n_cmp++; if (bad_fld != 0) begin n_bad++;
      $display("FAIL %s imem request: got %0d bad cycles want 0", tag, bad_fld); end
    n_cmp++; if (MBR !== imem_tbl[pc[7:0]]) begin n_bad++;
      $display("FAIL %s MBR: got %h want %h", tag, MBR, imem_tbl[pc[7:0]]); end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (MDR_out !== 32'h0 || MBR !== 8'h0) begin n_bad++;
      $display("FAIL reset regs: got MDR=%h MBR=%h want 0/0", MDR_out, MBR); end
    n_cmp++; if ({mdr_load, mbr_load, stall, proto_err} !== 4'b0) begin n_bad++;
      $display("FAIL reset flags: got %b want 0000", {mdr_load, mbr_load, stall, proto_err}); end
    n_cmp++; if ({mem_req, mem_we, imem_req} !== 3'b0) begin n_bad++;
      $display("FAIL reset requests: got %b want 000", {mem_req, mem_we, imem_req}); end
  endtask

  task automatic test_zero_wait_read();
    data_txn(1'b1, 1'b0, 32'h10, 32'h0, 0, "zero_wait_read");
  endtask

  task automatic test_write_waits();
    data_txn(1'b0, 1'b1, 32'h20, 32'h1234_5678, 3, "write_3wait");
    data_txn(1'b1, 1'b0, 32'h20, 32'h0, 0, "write_readback");
  endtask

  task automatic test_concurrent();
    int st = 0, lc = 0, la = 0, bc = 0, ba = 0;
    logic [31:0] exp;
    exp = ref_mem[8'h44];
    dwait = 1; iwait = 3;
    MAR = 32'h44; PC = 32'd5; rd = 1'b1; fetch = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin rd = 1'b0; fetch = 1'b0; end
      if (stall) st++;
      if (mdr_load) begin lc++; la = c; end
      if (mbr_load) begin bc++; ba = c; end
      if (!stall) break;
    end
    n_cmp++; if (st != 4) begin n_bad++;
      $display("FAIL concurrent stall cycles: got %0d want 4", st); end
    n_cmp++; if (lc != 1 || la != 2) begin n_bad++;
      $display("FAIL concurrent mdr_load: got %0d at %0d want 1 at 2", lc, la); end
    n_cmp++; if (bc != 1 || ba != 4) begin n_bad++;
      $display("FAIL concurrent mbr_load: got %0d at %0d want 1 at 4", bc, ba); end
    n_cmp++; if (MBR !== 8'hA7 || MDR_out !== exp) begin n_bad++;
      $display("FAIL concurrent data: got MBR=%h MDR=%h want a7/%h", MBR, MDR_out, exp); end
    mdr_model = exp;
  endtask

  task automatic test_proto();
    data_txn(1'b1, 1'b1, 32'h30, $urandom, 2, "rd_wr_both");
    data_txn(1'b1, 1'b0, 32'h30, 32'h0, 1, "proto_sticky");
    do_reset();
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++;
      $display("FAIL proto_clear: got %b want 0", proto_err); end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    do_reset();
    dwait = 5; MAR = 32'h18; rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_bad++;
      $display("FAIL reset_mid req/stall: got %b%b want 00", mem_req, stall); end
    rst = 1'b0; force_dack = 1'b1;
    @(negedge clk);
    if (mdr_load) late++;
    force_dack = 1'b0;
    @(negedge clk);
    n_cmp++; if (late != 0 || MDR_out !== 32'h0) begin n_bad++;
      $display("FAIL reset_mid late ack: got load=%0d MDR=%h want 0/0", late, MDR_out); end
    mdr_model = '0; proto_model = 1'b0;
  endtask

  task automatic test_random_data();
    logic [31:0] a;
    int k;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      a[7:0] = 8'($urandom_range(64, 79));
      k = $urandom_range(0, 1);
      data_txn(k == 0, k == 1, a, $urandom, $urandom_range(0, 3), "random_data");
    end
  endtask

  task automatic test_random_fetch();
    for (int i = 0; i < 8; i++) begin
      do_reset();
      fetch_txn($urandom, $urandom_range(0, 3), "random_fetch");
    end
  endtask

`ifdef MIC1_MEMCTL_PREFETCH_EN
  task automatic test_prefetch();
    do_reset();
    fetch_txn(32'd7, 0, "pf_first");
    repeat (3) @(negedge clk);
    PC = 32'd8; fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    n_cmp++; if (mbr_load !== 1'b1 || stall !== 1'b0) begin n_bad++;
      $display("FAIL pf_hit pulse: got load=%b stall=%b want 1/0", mbr_load, stall); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd9) begin n_bad++;
      $display("FAIL pf_refill: got req=%b addr=%h want 1/9", imem_req, imem_addr); end
    @(negedge clk);
    n_cmp++; if (MBR !== imem_tbl[8] || stall !== 1'b0) begin n_bad++;
      $display("FAIL pf_hit data: got %h stall=%b want %h/0", MBR, stall, imem_tbl[8]); end
    repeat (2) @(negedge clk);
    fetch_txn(32'h40, 1, "pf_miss");
    data_txn(1'b0, 1'b1, 32'h80, $urandom, 0, "pf_wr");
    fetch_txn(32'h41, 0, "pf_invalidated");
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
      imem_tbl[i] = 8'($urandom);
    end
    init_mem[8'h10] = 32'hDEAD_BEEF; ref_mem[8'h10] = 32'hDEAD_BEEF;
    init_mem[8'h00] = 32'hCAFE_F00D; ref_mem[8'h00] = 32'hCAFE_F00D;
    imem_tbl[5] = 8'hA7;
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_concurrent();
    test_proto();
    test_reset_mid();
    test_random_data();
    test_random_fetch();
`ifdef MIC1_MEMCTL_PREFETCH_EN
    test_prefetch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mic1_memctl.md
# mic1_memctl

Memory-side counterpart of the MIC-1 microsequencer. It consumes the read, write and fetch strobes of the current microinstruction, runs the word-data and byte-instruction transactions against external memory, and returns loaded data on MDR and MBR. MBR is the opcode byte the sequencer ORs into the next MPC. While any transaction is outstanding it raises `stall`, which freezes MPC and MIR.

## Interface
Parameters:
- `ADDR_W`, 32: width of word address (MAR) and byte address (PC).
- `DATA_W`, 32: data word width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd`  in  1  MIR read strobe (word read at MAR into MDR).
- `wr`  in  1  MIR write strobe (word write of MDR at MAR).
- `fetch`  in  1  MIR fetch strobe (byte read at PC into MBR).
- `MAR`  in  ADDR_W  word address.
- `MDR_in`  in  DATA_W  write data.
- `PC`  in  ADDR_W  byte address.
- `MDR_out`  out  DATA_W  read data register.
- `mdr_load`  out  1  one-cycle pulse; MDR_out updated this cycle.
- `MBR`  out  8  fetched byte register.
- `mbr_load`  out  1  one-cycle pulse; MBR updated this cycle.
- `stall`  out  1  transaction outstanding; sequencer holds MPC/MIR.
- `proto_err`  out  1  sticky; set by `rd`&`wr` in the same cycle.
- `mem_req`, `mem_we`  out  1  data-port request and write enable.
- `mem_addr`  out  ADDR_W  data-port word address.
- `mem_wdata`  out  DATA_W  data-port write data.
- `mem_ack`  in  1  data-port completion.
- `mem_rdata`  in  DATA_W  data-port read data, valid with `mem_ack`.
- `imem_req`  out  1  byte-port request.
- `imem_addr`  out  ADDR_W  byte-port address.
- `imem_ack`  in  1  byte-port completion.
- `imem_rdata`  in  8  byte-port read data, valid with `imem_ack`.

## Operation
- The data port and the byte port are independent. Each has its own FSM, `IDLE` -> `BUSY` -> `IDLE`.
- Acceptance:
  - Strobes are sampled only when the matching port FSM is `IDLE` and `stall` is low.
  - While `stall` is high the MIR is frozen, so repeated strobes are ignored.
- `IDLE` -> `BUSY`:
  - On the accepting edge, register the address, `mem_we` and write data.
  - Drive `mem_req`/`imem_req` high from the next cycle.
- `BUSY`:
  - Hold the request and all request fields stable until the ack is sampled high.
  - On the ack edge: return to `IDLE`, drop the request, and latch the read data into `MDR_out`/`MBR` with a one-cycle load pulse.
  - Writes produce no `mdr_load`.
- `rd` and `wr` asserted together: the write is issued, the read is dropped, and `proto_err` is set. `proto_err` clears only on `rst`.
- `fetch` together with `rd` or `wr` is legal; the two ports run concurrently.
- `stall` = data FSM `BUSY` OR byte FSM `BUSY`. It is a registered term with no combinational path from the strobes.
- An ack received while a port is `IDLE` is ignored.
- Reset values:
  - `MDR_out`=0, `MBR`=0.
  - All pulses and requests 0, `stall`=0, `proto_err`=0.
  - Both FSMs `IDLE`; prefetch buffer invalid.
- Reset mid-transaction: the request drops in the cycle after reset and any late ack is discarded.

## Timing
- Strobe in cycle k -> request high in k+1.
- With a zero-wait memory (ack in k+1), data is latched at the end of k+1, the load pulse occurs in k+1, `stall` is high only in k+1, and the data is usable in k+2. This matches the MIC-1 two-cycle read rule.
- Each wait state adds one cycle to both `stall` and latency.
- Back-to-back transactions: a strobe in the cycle after the ack (`stall` now low) is accepted, giving a minimum of 2 cycles per transaction.

## Configuration
- `MIC1_MEMCTL_PREFETCH_EN` defined:
  - After each completed fetch at address A, the byte port automatically requests A+1 into a one-byte buffer.
  - Address wrap-around at 2^ADDR_W is modulo.
  - A `fetch` whose PC equals the buffered address with the buffer valid loads `MBR` on the next edge: `mbr_load` in k+1, no `stall`, no new request. The buffer then refills at PC+1.
  - A `fetch` while the prefetch is outstanding to the same address joins it with no reissue.
  - A `fetch` to a different address waits for the prefetch ack, discards it, then issues.
  - Any `wr` invalidates the buffer.
- Undefined: no buffer; every fetch issues a transaction.

## Structure
- Shared package `mic1_pkg`:
  - port FSM state typedef (`IDLE`, `BUSY`);
  - MIR strobe bit positions (write, read, fetch);
  - `ADDR_W`/`DATA_W` defaults.
- One sub-module, `mic1_mem_port`: a generic request/ack FSM with address/data capture. It is instantiated twice, once at `DATA_W` and once at 8 bits.

## Test plan
- Zero-wait read: `MAR`=0x10, `rd`, memory returns 0xDEADBEEF with ack in k+1 -> `mdr_load` in k+1, `MDR_out`=0xDEADBEEF in k+2, `stall` high only in k+1.
- Write with 3 wait states: `MAR`=0x20, `MDR_in`=0x12345678, `wr` -> `mem_req`/`mem_we` held for 4 cycles, `stall` high 4 cycles, no `mdr_load`.
- Concurrent `rd` and `fetch`: `rd` acked after 1 wait, byte port (`PC`=5, byte 0xA7) after 3 waits -> `stall` high until the later ack, `MBR`=0xA7, both load pulses seen.
- `rd`&`wr` together -> exactly one write on the bus, `proto_err`=1, persisting until `rst`.
- Reset in the second busy cycle -> `mem_req` low the next cycle, a late ack is ignored, `MDR_out` stays 0.
- PREFETCH_EN: fetch PC=7 then PC=8 -> second fetch gives `mbr_load` in k+1 with no `stall`. A following fetch at PC=0x40 issues a fresh request.
